// File: rtl/byte_stream_packer.sv
// rtl/byte_stream_packer.sv - packs accepted bytes little-endian into 32-bit words behind a FWFT word FIFO with TLAST framing
// Optional BYTE_STREAM_PACKER_TEST_PATTERN_EN replaces in_data with an incrementing byte counter.
module byte_stream_packer #(
  parameter int PACKET_WORDS = 256,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic [31:0]                   m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LAST_CNT = 16'(PACKET_WORDS - 1);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {FILL0, FILL1, FILL2, FILL3} fill_t;

  fill_t       state, state_nxt;
  logic [23:0] partial;
  logic [7:0]  byte_in;
  logic        accept;
  logic        complete;

  assign accept = enable && in_valid;

`ifdef BYTE_STREAM_PACKER_TEST_PATTERN_EN
  logic [7:0] pattern;

  always_ff @(posedge clk) begin
    if (!rst_n)      pattern <= 8'h00;
    else if (accept) pattern <= pattern + 8'h01;
  end

  assign byte_in = pattern;
`else
  assign byte_in = in_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    if (!enable) begin
      state_nxt = FILL0;
    end else if (in_valid) begin
      case (state)
        FILL0: state_nxt = FILL1;
        FILL1: state_nxt = FILL2;
        FILL2: state_nxt = FILL3;
        FILL3: begin
          state_nxt = FILL0;
          complete  = 1'b1;
        end
        default: state_nxt = FILL0;
      endcase
    end
  end

  // Stale bytes need no clearing: FILL0..FILL2 rewrite every lane before the next completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      partial <= 24'h0;
    end else if (accept) begin
      case (state)
        FILL0:   partial[7:0]   <= byte_in;
        FILL1:   partial[15:8]  <= byte_in;
        FILL2:   partial[23:16] <= byte_in;
        default: partial        <= partial;
      endcase
    end
  end

  logic [32:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [15:0] pkt_cnt;
  logic        empty, full, pop, push, drop, is_last;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop     = !empty && m_tready;
  assign push    = complete && (!full || pop);
  assign drop    = complete && !push;
  assign is_last = (pkt_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {is_last, byte_in, partial};
  end

  // Framing counts delivered words only, so a drop never shifts the TLAST position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= 16'h0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        pkt_cnt <= is_last ? 16'h0 : pkt_cnt + 16'h1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign m_tvalid   = !empty;
  assign m_tdata    = empty ? 32'h0 : mem[rd_ptr[AW-1:0]][31:0];
  assign m_tlast    = empty ? 1'b0  : mem[rd_ptr[AW-1:0]][32];
  assign fifo_level = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_byte_stream_packer.sv
// tb/tb_byte_stream_packer.sv - self-checking bench for byte_stream_packer against a queue-based model
module tb_byte_stream_packer;
  localparam int PW    = 4;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n, enable, in_valid, m_tready, clr_ovf;
  logic [7:0]    in_data;
  logic [31:0]   m_tdata;
  logic          m_tvalid, m_tlast, overflow;
  logic [LW-1:0] fifo_level;

  always #5 clk = ~clk;

  byte_stream_packer #(.PACKET_WORDS(PW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_data(in_data), .in_valid(in_valid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .overflow(overflow), .clr_ovf(clr_ovf), .fifo_level(fifo_level)
  );

  logic [32:0] mq[$];
  logic [7:0]  part[$];
  logic [32:0] got[$];
  logic        m_ovf;
  int          pcnt;
  logic [7:0]  pat;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic        pop, complete;
    logic [31:0] word;
    logic        last;
    if (!rst_n) begin
      mq.delete(); part.delete(); m_ovf = 1'b0; pcnt = 0; pat = 8'h00;
      return;
    end
    pop = (mq.size() != 0) && m_tready;
    complete = 1'b0;
    word = 32'h0;
    if (enable && in_valid) begin
`ifdef BYTE_STREAM_PACKER_TEST_PATTERN_EN
      part.push_back(pat);
`else
      part.push_back(in_data);
`endif
      pat = pat + 8'h01;
      if (part.size() == 4) begin
        word = {part[3], part[2], part[1], part[0]};
        part.delete();
        complete = 1'b1;
      end
    end else if (!enable) begin
      part.delete();
    end
    if (pop) void'(mq.pop_front());
    if (complete) begin
      if (mq.size() < DEPTH) begin
        last = (pcnt == PW - 1);
        pcnt = (pcnt + 1) % PW;
        mq.push_back({last, word});
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (!(complete && m_ovf && mq.size() >= DEPTH) && clr_ovf && !(complete && !pop && mq.size() == DEPTH))
      m_ovf = m_ovf;
  endtask

  // Overflow update is done separately so "drop wins over clear" is explicit.
  task automatic tick();
    logic will_drop;
    will_drop = rst_n && enable && in_valid && (part.size() == 3)
                && (mq.size() == DEPTH) && !m_tready;
    if (m_tvalid && m_tready && rst_n) got.push_back({m_tlast, m_tdata});
    model_edge();
    if (rst_n && !will_drop && clr_ovf) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("tvalid", 33'(m_tvalid), 33'(mq.size() != 0));
    chk("tdata",  33'(m_tdata), (mq.size() != 0) ? 33'(mq[0][31:0]) : 33'h0);
    chk("tlast",  33'(m_tlast), (mq.size() != 0) ? 33'(mq[0][32]) : 33'h0);
    chk("overflow", 33'(overflow), 33'(m_ovf));
    chk("level", 33'(fifo_level), 33'(mq.size()));
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; clr_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = 8'h00; m_tready = 1'b0; clr_ovf = 1'b0;
    m_ovf = 1'b0; pcnt = 0; pat = 8'h00;
    tick(); tick();
    chk("rst_tvalid", 33'(m_tvalid), 33'h0);
    chk("rst_level", 33'(fifo_level), 33'h0);
    rst_n = 1'b1;

    // streaming
    enable = 1'b1; m_tready = 1'b1; got.delete();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    repeat (3) tick();
    chk("stream_count", 33'(got.size()), 33'd1);
`ifdef BYTE_STREAM_PACKER_TEST_PATTERN_EN
    if (got.size() > 0) chk("stream_word", got[0], {1'b0, 32'h03020100});
`else
    if (got.size() > 0) chk("stream_word", got[0], {1'b0, 32'h44332211});
`endif

    // framing
    do_reset(); got.delete();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("frame_count", 33'(got.size()), 33'd5);
    if (got.size() == 5) begin
      chk("frame_w0", got[0], {1'b0, 32'h03020100});
      chk("frame_w3", got[3], {1'b1, 32'h0F0E0D0C});
      chk("frame_w4", got[4], {1'b0, 32'h13121110});
    end

    // backpressure and overflow
    do_reset(); got.delete(); m_tready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      if (i == 35) chk("ovf_after_9th", 33'(overflow), 33'h1);
    end
    in_valid = 1'b0;
    tick();
    chk("bp_level", 33'(fifo_level), 33'd8);
    chk("bp_ovf", 33'(overflow), 33'h1);
    m_tready = 1'b1;
    repeat (10) tick();
    chk("drain_count", 33'(got.size()), 33'd8);
    for (int k = 0; k < 8 && k < got.size(); k++)
      chk("drain_word", got[k], {1'(k % 4 == 3), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0; tick();
    chk("clr_ovf", 33'(overflow), 33'h0);

    // full with simultaneous pop
    do_reset(); m_tready = 1'b0;
    for (int i = 0; i < 35; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    chk("full_level", 33'(fifo_level), 33'd8);
    m_tready = 1'b1; in_data = 8'd35;
    tick();
    in_valid = 1'b0; m_tready = 1'b0;
    chk("fullpop_level", 33'(fifo_level), 33'd8);
    chk("fullpop_ovf", 33'(overflow), 33'h0);

    // enable drop
    do_reset(); m_tready = 1'b1; got.delete(); repeat (12) tick(); got.delete();
    send(8'hAA); send(8'hBB);
    enable = 1'b0; tick(); enable = 1'b1;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    repeat (3) tick();
    chk("en_count", 33'(got.size()), 33'd1);
`ifdef BYTE_STREAM_PACKER_TEST_PATTERN_EN
    if (got.size() > 0) chk("en_word", got[0], {1'b0, 32'h05040302});
`else
    if (got.size() > 0) chk("en_word", got[0], {1'b0, 32'h04030201});
`endif

    // reset mid-operation
    m_tready = 1'b0;
    for (int i = 0; i < 14; i++) send(8'(8'h50 + i));
    chk("pre_rst_level", 33'(fifo_level), 33'd3);
    do_reset();
    chk("mid_rst_tvalid", 33'(m_tvalid), 33'h0);
    chk("mid_rst_level", 33'(fifo_level), 33'h0);
    chk("mid_rst_ovf", 33'(overflow), 33'h0);
    m_tready = 1'b1; got.delete();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    repeat (2) tick();
    chk("post_rst_count", 33'(got.size()), 33'd1);
`ifdef BYTE_STREAM_PACKER_TEST_PATTERN_EN
    if (got.size() > 0) chk("post_rst_word", got[0], {1'b0, 32'h03020100});
`else
    if (got.size() > 0) chk("post_rst_word", got[0], {1'b0, 32'h04030201});
`endif

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      enable   = ($urandom_range(0, 15) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      m_tready = ($urandom_range(0, 2) == 0);
      clr_ovf  = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
